// File: rtl/fwft_packer_pkg.sv
// rtl/fwft_packer_pkg.sv - shared state enum and helpers for the FWFT word packer
package fwft_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Elaboration-time ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic logic lane_sel(input int wr_idx, input int lane);
    return wr_idx == lane;
  endfunction

endpackage

// File: rtl/fwft_word_packer.sv
// rtl/fwft_word_packer.sv - packs NUM_WORDS FWFT FIFO entries into one wide valid/ready beat
// Optional partial-word flush port enabled by FWFT_PACKER_FLUSH_EN.
module fwft_word_packer
  import fwft_packer_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int NUM_WORDS = 4,
  parameter int OUT_WIDTH = IN_WIDTH * NUM_WORDS,
  parameter int CNT_WIDTH = clog2(NUM_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_data,
  output logic                 fifo_pop,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef FWFT_PACKER_FLUSH_EN
  input  logic                 flush,
`endif
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam int                   IDX_WIDTH = clog2(NUM_WORDS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(NUM_WORDS);

  pack_state_e            state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [OUT_WIDTH-1:0]   lanes_q, lanes_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   handshake;
  logic [IDX_WIDTH-1:0]   wr_idx;
`ifdef FWFT_PACKER_FLUSH_EN
  logic [CNT_WIDTH-1:0]   fill_n;
`endif

  // A beat leaving in the same cycle frees the buffer, so the head entry can be taken at once.
  assign handshake = (state_q == HOLD) && out_ready;
  assign fifo_pop  = !reset && !fifo_empty && ((state_q == FILL) || handshake);

  assign out_valid = (state_q == HOLD);
  assign out_data  = lanes_q;
  assign out_count = count_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    count_d = count_q;
    wr_idx  = idx_q;
`ifdef FWFT_PACKER_FLUSH_EN
    fill_n  = '0;
`endif

    if (handshake) begin
      lanes_d = '0;
      count_d = '0;
      idx_d   = '0;
      state_d = FILL;
      wr_idx  = '0;
    end

    if (fifo_pop) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (lane_sel(int'(wr_idx), i)) begin
          lanes_d[i*IN_WIDTH +: IN_WIDTH] = fifo_data;
        end
      end
      if (wr_idx == LAST_IDX) begin
        state_d = HOLD;
        count_d = FULL_CNT;
        idx_d   = '0;
      end else begin
        idx_d = wr_idx + IDX_WIDTH'(1);
      end
    end

`ifdef FWFT_PACKER_FLUSH_EN
    // Lanes filled so far, counting one landing this cycle; a full count matches normal completion.
    fill_n = CNT_WIDTH'(idx_q) + CNT_WIDTH'(fifo_pop);
    if ((state_q == FILL) && flush && (fill_n != '0)) begin
      state_d = HOLD;
      count_d = fill_n;
      idx_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      lanes_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      count_q <= count_d;
    end
  end

endmodule
